// File: rtl/fma16_normround.sv
// Post-add normalize/round back end of the binary16 FMA: leading-one detect and
// shift in stage 1, round-to-nearest-even and pack in stage 2, valid/ready on both ends.
module fma16_normround #(
    parameter int SUMW = 34,
    parameter int EW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SUMW-1:0] in_sm,
    input  logic [EW-1:0]   in_se,
    input  logic            in_ss,
    input  logic            in_sticky,
    input  logic            in_nan,
    input  logic            in_inf,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_r,
    output logic            out_ovf,
    output logic            out_unf,
    output logic            out_nx
);
    typedef struct packed {
        logic               sign;
        logic signed [10:0] e;
        logic [10:0]        kept;
        logic               guard;
        logic               sticky;
        logic               nan;
        logic               inf;
        logic               zero;
    } s1_t;

    logic        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    s1_t         s1_q, s1_d;
    logic [15:0] r_q, r_d;
    logic        ovf_q, ovf_d, unf_q, unf_d, nx_q, nx_d;
    logic        s2_adv, s1_load, s2_load;

    assign s2_adv   = !s2_valid_q | out_ready;
    assign in_ready = !s1_valid_q | s2_adv;
    assign s1_load  = in_valid & in_ready;
    assign s2_load  = s1_valid_q & s2_adv;

    // Stage 1: leading one, biased exponent, and ulp position (extra right
    // shift when the result lands in the subnormal range).
    logic [5:0]         lead;
    logic signed [10:0] e_in, u;
    logic signed [11:0] rel;
    always_comb begin
        lead = '0;
        for (int i = 0; i < SUMW; i++)
            if (in_sm[i]) lead = 6'(i);
        e_in = {{(11-EW){in_se[EW-1]}}, in_se} + {5'b0, lead} - 11'd30;
        u    = {5'b0, lead} - 11'd10 + ((e_in < 11'sd1) ? (11'd1 - e_in) : 11'd0);
        rel  = '0;
        s1_d = s1_q;
        s1_d.sign   = in_ss;
        s1_d.e      = e_in;
        s1_d.kept   = '0;
        s1_d.guard  = 1'b0;
        s1_d.sticky = in_sticky;
        s1_d.nan    = in_nan;
        s1_d.inf    = in_inf;
        s1_d.zero   = (in_sm == '0);
        for (int j = 0; j < SUMW; j++) begin
            rel = 12'(j) - {u[10], u};
            if (rel >= 12'sd0 && rel <= 12'sd10) s1_d.kept[rel[3:0]] = in_sm[j];
            else if (rel == -12'sd1)             s1_d.guard = in_sm[j];
            else if (rel < -12'sd1)              s1_d.sticky = s1_d.sticky | in_sm[j];
        end
    end

    // Stage 2: RNE, carry renormalization, overflow saturation to infinity.
    logic               normal, ru, nx_c, unf_c;
    logic [11:0]        m;
    logic [10:0]        mn;
    logic signed [10:0] ef;
    always_comb begin
        normal = $signed(s1_q.e) > 11'sd0;
        ru     = s1_q.guard & (s1_q.sticky | s1_q.kept[0]);
        m      = {1'b0, s1_q.kept} + {11'd0, ru};
        mn     = m[11] ? m[11:1] : m[10:0];
        ef     = normal ? $signed(s1_q.e) + $signed({10'd0, m[11]}) : $signed({10'd0, m[10]});
        nx_c   = s1_q.guard | s1_q.sticky;
        unf_c  = (!normal | !mn[10]) & nx_c;
        r_d    = r_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        nx_d   = nx_q;
        if (s2_load) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            nx_d  = 1'b0;
            if (s1_q.nan)                      r_d = 16'h7E00;
            else if (s1_q.inf)                 r_d = {s1_q.sign, 15'h7C00};
            else if (s1_q.zero & !s1_q.sticky) r_d = {s1_q.sign, 15'h0};
            else if (ef >= 11'sd31) begin
                r_d   = {s1_q.sign, 5'h1F, 10'h0};
                ovf_d = 1'b1;
                nx_d  = 1'b1;
            end else begin
                r_d   = {s1_q.sign, ef[4:0], mn[9:0]};
                unf_d = unf_c;
                nx_d  = nx_c;
            end
        end
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            r_q        <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            nx_q       <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (s1_load) s1_q <= s1_d;
            r_q        <= r_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            nx_q       <= nx_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_r     = r_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;
    assign out_nx    = nx_q;
endmodule
